// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and FSM state encoding for the outbound MIDI serializer.
// Status-byte range helpers are used by the running-status filter (MIDI_RUNNING_STATUS_EN).

package midi_pkg;

    // Standard MIDI serial bit rate.
    localparam int unsigned MIDI_BAUD = 31250;

    // Status byte ranges.
    localparam logic [7:0] CH_STATUS_LO  = 8'h80;
    localparam logic [7:0] CH_STATUS_HI  = 8'hEF;
    localparam logic [7:0] SYS_COMMON_HI = 8'hF7;
    localparam logic [7:0] REALTIME_LO   = 8'hF8;

    // Transmit FSM state encoding.
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t IDLE  = 2'd0;
    localparam tx_state_t START = 2'd1;
    localparam tx_state_t DATA  = 2'd2;
    localparam tx_state_t STOP  = 2'd3;

    // Channel voice/mode status (0x80-0xEF).
    function automatic logic is_ch_status(input logic [7:0] b);
        return (b >= CH_STATUS_LO) && (b <= CH_STATUS_HI);
    endfunction

    // System common / sysex status (0xF0-0xF7); cancels running status.
    function automatic logic is_sys_common(input logic [7:0] b);
        return (b > CH_STATUS_HI) && (b <= SYS_COMMON_HI);
    endfunction

    // System realtime (0xF8-0xFF); transparent to running status.
    function automatic logic is_realtime(input logic [7:0] b);
        return b >= REALTIME_LO;
    endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// midi_byte_fifo: synchronous show-ahead FIFO with registered full/level.
// A write while full is dropped (drop_o pulses) even if a read happens in the same cycle,
// so the full flag alone decides acceptance. Reads on an empty FIFO are ignored.

module midi_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic             drop_o
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, full_d;
    logic              push, pop;

    assign push    = wr_en_i && !full_q;
    assign pop     = rd_en_i && (level_q != '0);
    assign drop_o  = wr_en_i && full_q;
    assign empty_o = (level_q == '0);
    assign full_o  = full_q;
    assign level_o = level_q;

    // Head of queue is presented combinationally.
    assign rd_data_o = mem_q[rd_ptr_q];

    // Next-state pointers, level and full flag; pointers wrap since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_W'(DEPTH));
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // Storage array; no reset needed, contents are only read behind the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/midi_uart_tx.sv
// midi_uart_tx: outbound MIDI serializer (8N1, LSB first, true polarity, idle high).
// Bytes are queued in midi_byte_fifo and shifted out back-to-back with no idle gap.
// Optional build macro MIDI_RUNNING_STATUS_EN: suppresses a channel status byte that
// repeats the current running status instead of sending it.

module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = MIDI_BAUD,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             fpga_clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             ovf_clr,
    output logic             full,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic             busy,
    output logic             midi_txd
);

    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             ovf_q, ovf_d;

    logic             fifo_pop;
    logic [7:0]       fifo_rd;
    logic             fifo_empty;
    logic             fifo_drop;
    logic             send_ok;
    logic             bit_end;

    midi_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_i     (fpga_clk),
        .rst_i     (reset),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd),
        .full_o    (full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level),
        .drop_o    (fifo_drop)
    );

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status_q, last_status_d;
    logic       discard;

    // Running-status filter: decide whether the head byte is sent and track last status.
    always_comb begin
        discard       = is_ch_status(fifo_rd) && (fifo_rd == last_status_q);
        last_status_d = last_status_q;
        if (fifo_pop && !discard) begin
            if (is_ch_status(fifo_rd)) begin
                last_status_d = fifo_rd;
            end else if (is_sys_common(fifo_rd)) begin
                last_status_d = 8'h00;
            end
        end
    end

    // Running-status register.
    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            last_status_q <= 8'h00;
        end else begin
            last_status_q <= last_status_d;
        end
    end

    assign send_ok = !discard;
`else
    assign send_ok = 1'b1;
`endif

    // The counter sits at reload in IDLE, so every bit is exactly BAUD_DIV cycles.
    assign bit_end = (cnt_q == '0);

    // Transmit FSM, baud counter and shift register next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        if (state_q == IDLE) begin
            cnt_d = CNT_RELOAD;
        end else if (bit_end) begin
            cnt_d = CNT_RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (send_ok) begin
                        shift_d = fifo_rd;
                        state_d = START;
                    end
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (send_ok) begin
                            shift_d = fifo_rd;
                            state_d = START;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the current state; registered so midi_txd is glitch-free.
    always_comb begin
        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Sticky overflow; a new drop beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Transmitter state registers.
    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_RELOAD;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign midi_txd = txd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx with a short bit period (16 cycles per bit).
module tb_midi_uart_tx;

    localparam int unsigned CLK_HZ = 500000;
    localparam int unsigned BAUD   = 31250;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int          B      = CLK_HZ / BAUD;

    logic             fpga_clk;
    logic             reset;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             ovf_clr;
    logic             full;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             busy;
    logic             midi_txd;

    midi_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .LVL_W      (LVL_W)
    ) dut (
        .fpga_clk   (fpga_clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .full       (full),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .busy       (busy),
        .midi_txd   (midi_txd)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         mon_ferr = 0;
    logic [7:0] tx_seq [$];

    // Line receiver: samples each bit at its midpoint, records bytes and start cycles.
    bit         mon_act = 0;
    int         mon_n = 0;
    int         mon_t = 0;
    logic [7:0] mon_sh = 8'h00;
    initial begin
        forever begin
            @(negedge fpga_clk);
            if (reset === 1'b1) begin
                mon_act = 0;
            end else if (!mon_act) begin
                if (midi_txd === 1'b0) begin
                    mon_act = 1;
                    mon_n   = 0;
                    mon_t   = cyc;
                end
            end else begin
                mon_n++;
                if (mon_n % B == B / 2) begin
                    if (mon_n / B == 0) begin
                        if (midi_txd !== 1'b0) begin
                            mon_ferr++;
                            mon_act = 0;
                        end
                    end else if (mon_n / B <= 8) begin
                        mon_sh[mon_n / B - 1] = midi_txd;
                    end else begin
                        if (midi_txd !== 1'b1) mon_ferr++;
                        rx_q.push_back(mon_sh);
                        rx_t.push_back(mon_t);
                        mon_act = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        rx_q.delete();
        rx_t.delete();
        mon_ferr = 0;
    endtask

    task automatic drive_seq();
        foreach (tx_seq[i]) begin
            wr_en   = 1'b1;
            wr_data = tx_seq[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 0;
        for (int n = 0; n < max_cyc; n++) begin
            tick();
            if (busy === 1'b0 && fifo_level === '0) begin
                ok = 1;
                break;
            end
        end
        repeat (B) tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (midi_txd !== 1'b1) begin
            miscompares++; $display("FAIL reset_txd: got %b want 1", midi_txd);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (full !== 1'b0) begin
            miscompares++; $display("FAIL reset_full: got %b want 0", full);
        end
        vectors++;
        if (fifo_level !== '0) begin
            miscompares++; $display("FAIL reset_level: got %0d want 0", fifo_level);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] fr;
        int busy_cnt;
        int bad;
        fr = {1'b1, 8'h90, 1'b0};
        do_reset();
        wr_en   = 1'b1;
        wr_data = 8'h90;
        tick();
        wr_en = 1'b0;
        tick();
        // One edge after the write: popped, FSM in START, line not yet low.
        vectors++;
        if (midi_txd !== 1'b1 || busy !== 1'b1 || fifo_level !== '0) begin
            miscompares++;
            $display("FAIL single_pop: got txd=%b busy=%b lvl=%0d want 1 1 0",
                     midi_txd, busy, fifo_level);
        end
        busy_cnt = 1;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < B; c++) begin
                tick();
                if (midi_txd !== fr[b]) bad++;
                if (busy === 1'b1) busy_cnt++;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL single_bit%0d: %0d cycles wrong, want level %b", b, bad, fr[b]);
            end
        end
        vectors++;
        if (busy_cnt != 10 * B) begin
            miscompares++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, 10 * B);
        end
        repeat (4) tick();
        vectors++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h90 || mon_ferr != 0) begin
            miscompares++;
            $display("FAIL single_rx: got n=%0d b0=%h ferr=%0d want 1 90 0",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, mon_ferr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int busy_cnt;
        exp_b = '{8'h90, 8'h3C, 8'h64};
        do_reset();
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = exp_b[i];
            tick();
            if (busy === 1'b1) busy_cnt++;
        end
        wr_en = 1'b0;
        for (int n = 0; n < 40 * B; n++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            else break;
        end
        repeat (B) tick();
        vectors++;
        if (busy_cnt != 30 * B) begin
            miscompares++; $display("FAIL b2b_busy_len: got %0d want %0d", busy_cnt, 30 * B);
        end
        vectors++;
        if (busy !== 1'b0 || fifo_level !== '0) begin
            miscompares++;
            $display("FAIL b2b_idle: got busy=%b lvl=%0d want 0 0", busy, fifo_level);
        end
        vectors++;
        if (rx_q.size() != 3 || rx_q[0] !== exp_b[0] || rx_q[1] !== exp_b[1] ||
            rx_q[2] !== exp_b[2] || mon_ferr != 0) begin
            miscompares++;
            $display("FAIL b2b_bytes: got n=%0d ferr=%0d want 90 3c 64", rx_q.size(), mon_ferr);
        end
        vectors++;
        if (rx_t.size() != 3 || rx_t[1] - rx_t[0] != 10 * B || rx_t[2] - rx_t[1] != 10 * B) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d frames want start spacing %0d", rx_t.size(), 10 * B);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int bad;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h10 + i);
            tick();
            if (i == 16) begin
                vectors++;
                if (full !== 1'b1 || fifo_level !== LVL_W'(16) || overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_full: got full=%b lvl=%0d ovf=%b want 1 16 0",
                             full, fifo_level, overflow);
                end
            end
        end
        wr_en = 1'b0;
        vectors++;
        if (overflow !== 1'b1 || fifo_level !== LVL_W'(16)) begin
            miscompares++;
            $display("FAIL ovf_drop: got ovf=%b lvl=%0d want 1 16", overflow, fifo_level);
        end
        // Drop coinciding with clear: set wins.
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        ovf_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_set_wins: got %b want 1", overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        wait_idle(200 * B, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++; $display("FAIL ovf_drain_timeout: got %b want 1", ok);
        end
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            if (i >= rx_q.size() || rx_q[i] !== 8'(8'h10 + i)) bad++;
        end
        vectors++;
        if (rx_q.size() != 17 || bad != 0 || mon_ferr != 0) begin
            miscompares++;
            $display("FAIL ovf_bytes: got n=%0d bad=%0d ferr=%0d want 17 0 0",
                     rx_q.size(), bad, mon_ferr);
        end
        vectors++;
        if (full !== 1'b0 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL ovf_final: got full=%b ovf=%b want 0 0", full, overflow);
        end
    endtask

    task automatic test_running_status();
        logic [7:0] exp_q [$];
        bit ok;
        int bad;
        for (int s = 0; s < 3; s++) begin
            unique case (s)
                0: begin
                    tx_seq = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
`ifdef MIDI_RUNNING_STATUS_EN
                    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64};
`else
                    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
`endif
                end
                1: begin
                    tx_seq = '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h90, 8'h3E, 8'h40};
`ifdef MIDI_RUNNING_STATUS_EN
                    exp_q = '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h3E, 8'h40};
`else
                    exp_q = '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h90, 8'h3E, 8'h40};
`endif
                end
                default: begin
                    tx_seq = '{8'h90, 8'h3C, 8'h64, 8'hF2, 8'h90};
                    exp_q  = '{8'h90, 8'h3C, 8'h64, 8'hF2, 8'h90};
                end
            endcase
            do_reset();
            drive_seq();
            wait_idle(100 * B, ok);
            vectors++;
            if (ok !== 1'b1) begin
                miscompares++; $display("FAIL rs%0d_timeout: got %b want 1", s, ok);
            end
            vectors++;
            if (rx_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL rs%0d_frames: got %0d want %0d", s, rx_q.size(), exp_q.size());
            end
            bad = 0;
            foreach (exp_q[i]) begin
                if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
            end
            vectors++;
            if (bad != 0 || mon_ferr != 0) begin
                miscompares++;
                $display("FAIL rs%0d_bytes: got %0d wrong, ferr=%0d want 0 0", s, bad, mon_ferr);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        do_reset();
        tx_seq = '{8'hA5, 8'h12};
        drive_seq();
        // Now one edge after the first pop; move into the middle of data bit 3 (a 0 bit).
        repeat (4 * B + B / 2) tick();
        vectors++;
        if (midi_txd !== 1'b0 || busy !== 1'b1 || fifo_level !== LVL_W'(1)) begin
            miscompares++;
            $display("FAIL midrst_pre: got txd=%b busy=%b lvl=%0d want 0 1 1",
                     midi_txd, busy, fifo_level);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (midi_txd !== 1'b1 || busy !== 1'b0 || fifo_level !== '0) begin
            miscompares++;
            $display("FAIL midrst_async: got txd=%b busy=%b lvl=%0d want 1 0 0",
                     midi_txd, busy, fifo_level);
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        rx_q.delete();
        rx_t.delete();
        mon_ferr = 0;
        tx_seq = '{8'h55};
        drive_seq();
        wait_idle(20 * B, ok);
        vectors++;
        if (ok !== 1'b1 || rx_q.size() != 1 || rx_q[0] !== 8'h55 || mon_ferr != 0) begin
            miscompares++;
            $display("FAIL midrst_clean: got ok=%b n=%0d ferr=%0d want 1 1 0 byte 55",
                     ok, rx_q.size(), mon_ferr);
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_running_status();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
